serial_transceiver: RTL
=======================

SERIAL_TRANSCEIVER -- requirements
Module: serial_transceiver

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of the memory word serialised per transfer.
REQ-002 Clk  input  1  single system clock, all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 SampleData  input  1  controller request to capture DataIn into the shift register.
REQ-005 TransferData  input  1  controller request to start shifting the captured word out.
REQ-006 DataIn  input  DATA_WIDTH  parallel word read from memory.
REQ-007 SerialOut  output  1  serial data, MSB first.
REQ-008 SerialValid  output  1  high in each cycle SerialOut carries a valid bit.
REQ-009 Loaded  output  1  high while a captured word is waiting for TransferData.
REQ-010 TransferDone  output  1  one-cycle pulse: transfer complete, returned to the controller.

Function
REQ-011 The block SHALL implement FSM states IDLE, LOADED, SHIFT, DONE; all outputs registered.
REQ-012 IDLE: SampleData=1 SHALL capture DataIn into the shift register, clear the bit counter, and go to LOADED.
REQ-013 IDLE: TransferData=1 without a captured word SHALL be ignored (no shift, no TransferDone).
REQ-014 IDLE with SampleData=1 and TransferData=1 in the same cycle SHALL capture only, then go to LOADED.
REQ-015 LOADED: Loaded=1; SampleData=1 alone SHALL overwrite the captured word with the current DataIn and stay in LOADED.
REQ-016 LOADED: TransferData=1 SHALL go to SHIFT and take priority over a simultaneous SampleData, which is ignored.
REQ-017 SHIFT: each cycle SerialOut = current MSB, SerialValid=1, shift left by one, counter +1.
REQ-018 Counter width SHALL be clog2(DATA_WIDTH)+1; SHIFT SHALL exit to DONE after exactly DATA_WIDTH bits, with no wrap-around.
REQ-019 Latency: TransferData sampled at edge N -> first bit valid in cycle N+1, last bit in cycle N+DATA_WIDTH, TransferDone=1 in cycle N+DATA_WIDTH+1 only.
REQ-020 SHIFT/DONE: SampleData and TransferData SHALL be ignored.
REQ-021 DONE SHALL last one cycle, then go to IDLE; SerialValid=0 and SerialOut=0 outside SHIFT.
REQ-022 Back-to-back: SampleData in the first IDLE cycle after DONE SHALL be accepted normally.

Reset
REQ-023 Reset=1 at a clock edge SHALL force IDLE; shift register, counter, SerialOut, SerialValid, Loaded, and TransferDone all go to 0.
REQ-024 Reset mid-SHIFT SHALL abort the transfer with no TransferDone pulse; the remaining bits are discarded.
REQ-025 Reset SHALL take priority over every simultaneous input.

Structure
REQ-026 Package serial_pkg SHALL hold the state enum (IDLE/LOADED/SHIFT/DONE) and the DATA_WIDTH default constant.
REQ-027 The bit counter with a terminal-count flag SHALL be one sub-module, bit_counter; all other logic stays in serial_transceiver.

Verification
REQ-028 Reset, DataIn=8'hA5, SampleData 1 cycle, TransferData 1 cycle -> SerialOut 1,0,1,0,0,1,0,1 with SerialValid=1 for 8 cycles, then TransferDone=1 for 1 cycle.
REQ-029 TransferData pulse in IDLE with nothing loaded -> SerialValid and TransferDone stay 0 for 20 cycles.
REQ-030 Sample 8'hFF, then sample 8'h0F while LOADED, then TransferData -> serial stream 0,0,0,0,1,1,1,1.
REQ-031 Reset asserted after 3 bits of 8'hC3 -> outputs 0 next cycle, no TransferDone, next transfer of 8'h81 is correct.
REQ-032 SampleData and TransferData held high together from IDLE -> one capture, then shift; inputs ignored in SHIFT/DONE; TransferDone exactly DATA_WIDTH+2 cycles after the first high edge.
REQ-033 Two consecutive transfers (8'h3C, 8'hC3) with SampleData in the first IDLE cycle after DONE -> both streams correct, two TransferDone pulses.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial transceiver: FSM state encoding and default word width.
package serial_pkg;

    localparam int SERIAL_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/serial_transceiver_bit_counter.sv
// Bit counter for the shift phase; term_cnt flags that the next counted bit is the last of the word.
module bit_counter #(
    parameter int DATA_WIDTH = 8,
    localparam int CNT_W     = $clog2(DATA_WIDTH) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic term_cnt
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Saturates at DATA_WIDTH so a stray enable can never wrap the count.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != CNT_W'(DATA_WIDTH))) begin
            count_d = count_q + 1'b1;
        end
        term_cnt = (count_q == CNT_W'(DATA_WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/serial_transceiver.sv
// Captures a parallel memory word and shifts it out MSB first with registered valid/done handshakes.
module serial_transceiver
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH = SERIAL_DATA_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  SampleData,
    input  logic                  TransferData,
    input  logic [DATA_WIDTH-1:0] DataIn,
    output logic                  SerialOut,
    output logic                  SerialValid,
    output logic                  Loaded,
    output logic                  TransferDone
);

    state_t                state_d, state_q;
    logic [DATA_WIDTH-1:0] shreg_d, shreg_q;
    logic                  serial_out_d, serial_out_q;
    logic                  serial_valid_d, serial_valid_q;
    logic                  loaded_d, loaded_q;
    logic                  done_d, done_q;
    logic                  cnt_clr;
    logic                  cnt_en;
    logic                  cnt_last;

    bit_counter #(.DATA_WIDTH(DATA_WIDTH)) u_bit_counter (
        .clk      (Clk),
        .rst      (Reset),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .term_cnt (cnt_last)
    );

    always_comb begin
        state_d        = state_q;
        shreg_d        = shreg_q;
        serial_out_d   = 1'b0;
        serial_valid_d = 1'b0;
        done_d         = 1'b0;
        cnt_clr        = 1'b0;
        cnt_en         = 1'b0;
        case (state_q)
            IDLE: begin
                if (SampleData) begin
                    shreg_d = DataIn;
                    cnt_clr = 1'b1;
                    state_d = LOADED;
                end
            end
            LOADED: begin
                // A transfer request wins over a simultaneous re-sample.
                if (TransferData) begin
                    state_d = SHIFT;
                end else if (SampleData) begin
                    shreg_d = DataIn;
                    cnt_clr = 1'b1;
                end
            end
            SHIFT: begin
                serial_out_d   = shreg_q[DATA_WIDTH-1];
                serial_valid_d = 1'b1;
                shreg_d        = shreg_q << 1;
                cnt_en         = 1'b1;
                if (cnt_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        loaded_d = (state_d == LOADED);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= IDLE;
            shreg_q        <= '0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            loaded_q       <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
            loaded_q       <= loaded_d;
            done_q         <= done_d;
        end
    end

    assign SerialOut    = serial_out_q;
    assign SerialValid  = serial_valid_q;
    assign Loaded       = loaded_q;
    assign TransferDone = done_q;

endmodule
